// File: rtl/uart_tx_frame.sv
// UART transmit framer: takes one word per valid/ready handshake and shifts it
// out LSB-first as start, data, optional parity and stop bits. Each bit boundary
// is the rising edge of the baud level supplied by the baud generator.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 baud_in,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Index of the final data bit and of the final stop bit.
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t                 state_reg, state_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [2:0]             cnt_reg, cnt_next;
    logic                   stop_cnt_reg, stop_cnt_next;
    logic                   parity_reg, parity_next;
    logic                   baud_q_reg;
    logic                   tx_out_reg, tx_out_next;
    logic                   tx_ready_reg, tx_ready_next;
    logic                   tx_busy_reg, tx_busy_next;
    logic                   tx_done_reg, tx_done_next;
    logic                   tick;
    logic [DATA_BITS:0]     par_chain;

    // One-cycle pulse on each rising edge of the baud level.
    assign tick = baud_in & ~baud_q_reg;

    // Parity of the incoming word, seeded with the odd/even selection so the
    // chain output is exactly the bit that goes on the line.
    assign par_chain[0] = 1'(PARITY_ODD);
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ tx_data[gi];
        end
    endgenerate

    assign tx_out   = tx_out_reg;
    assign tx_ready = tx_ready_reg;
    assign tx_busy  = tx_busy_reg;
    assign tx_done  = tx_done_reg;

    // State and registered outputs; reset aborts any frame and idles the line high.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            cnt_reg      <= '0;
            stop_cnt_reg <= 1'b0;
            parity_reg   <= 1'b0;
            baud_q_reg   <= 1'b0;
            tx_out_reg   <= 1'b1;
            tx_ready_reg <= 1'b1;
            tx_busy_reg  <= 1'b0;
            tx_done_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            cnt_reg      <= cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            parity_reg   <= parity_next;
            baud_q_reg   <= baud_in;
            tx_out_reg   <= tx_out_next;
            tx_ready_reg <= tx_ready_next;
            tx_busy_reg  <= tx_busy_next;
            tx_done_reg  <= tx_done_next;
        end
    end

    // Next-state and next-output logic; every bit transition waits for a tick.
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        cnt_next      = cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        parity_next   = parity_reg;
        tx_out_next   = tx_out_reg;
        tx_ready_next = tx_ready_reg;
        tx_busy_next  = tx_busy_reg;
        tx_done_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tx_out_next = 1'b1;
                if (tx_valid && tx_ready_reg) begin
                    // A tick coinciding with accept is consumed here and ignored.
                    state_next    = ST_SYNC;
                    shift_next    = tx_data;
                    parity_next   = par_chain[DATA_BITS];
                    cnt_next      = '0;
                    stop_cnt_next = 1'b0;
                    tx_busy_next  = 1'b1;
                    tx_ready_next = 1'b0;
                end
            end
            ST_SYNC: begin
                if (tick) begin
                    state_next  = ST_START;
                    tx_out_next = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next  = ST_DATA;
                    tx_out_next = shift_reg[0];
                    shift_next  = shift_reg >> 1;
                    cnt_next    = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (cnt_reg != LAST_BIT) begin
                        cnt_next    = cnt_reg + 3'd1;
                        tx_out_next = shift_reg[0];
                        shift_next  = shift_reg >> 1;
                    end else if (PARITY_EN != 0) begin
                        state_next  = ST_PARITY;
                        tx_out_next = parity_reg;
                    end else begin
                        state_next    = ST_STOP;
                        tx_out_next   = 1'b1;
                        stop_cnt_next = 1'b0;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_next    = ST_STOP;
                    tx_out_next   = 1'b1;
                    stop_cnt_next = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt_reg == LAST_STOP) begin
                        state_next    = ST_IDLE;
                        tx_done_next  = 1'b1;
                        tx_busy_next  = 1'b0;
                        tx_ready_next = 1'b1;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                tx_out_next   = 1'b1;
                tx_ready_next = 1'b1;
                tx_busy_next  = 1'b0;
            end
        endcase
    end

endmodule
